gb_sweep_unit: RTL and testbench

GB_SWEEP_UNIT -- requirements
Module: gb_sweep_unit

---
 rtl/gb_sweep_unit.sv | 103 ++++++++++
 tb/tb_gb_sweep_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gb_sweep_unit.sv
// Frequency sweep unit for a Game Boy style square channel: shadow register,
// sweep timer, overflow check and frequency write-back sequencing.
module gb_sweep_unit #(
    parameter int FREQ_WIDTH  = 11,
    parameter int PACE_WIDTH  = 3,
    parameter int SHIFT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_sweep,
    input  logic                   trigger,
    input  logic [PACE_WIDTH-1:0]  sweep_pace,
    input  logic                   sweep_decreasing,
    input  logic [SHIFT_WIDTH-1:0] num_sweep_shifts,
    input  logic [FREQ_WIDTH-1:0]  frequency,
    output logic                   overflow,
    output logic [FREQ_WIDTH-1:0]  shadow_frequency,
    output logic                   freq_update_valid,
    output logic [FREQ_WIDTH-1:0]  freq_update
);

    // Timer must hold the substitute period of 8 used when the pace is zero.
    localparam int TIMER_WIDTH = (PACE_WIDTH > 4) ? PACE_WIDTH : 4;

    typedef enum logic [1:0] {IDLE, TRIG_CHECK, STEP_CALC, STEP_CHECK} state_t;

    state_t                 state, state_next;
    logic [TIMER_WIDTH-1:0] timer;
    logic [TIMER_WIDTH-1:0] reload;
    logic                   enabled;
    logic                   neg_used;
    logic [FREQ_WIDTH:0]    calc;
    logic [FREQ_WIDTH-1:0]  delta;
    logic                   calc_active;
    logic                   calc_ovf;
    logic                   write_back;
    logic                   tick_idle;
    logic                   lockout;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        if (trigger) begin
            state_next = (num_sweep_shifts != '0) ? TRIG_CHECK : IDLE;
        end else begin
            case (state)
                IDLE:
                    if (tick_idle && timer == TIMER_WIDTH'(1) && enabled && sweep_pace != '0)
                        state_next = STEP_CALC;
                STEP_CALC: state_next = STEP_CHECK;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        delta       = shadow_frequency >> num_sweep_shifts;
        calc        = sweep_decreasing ? ({1'b0, shadow_frequency} - {1'b0, delta})
                                       : ({1'b0, shadow_frequency} + {1'b0, delta});
        calc_ovf    = calc[FREQ_WIDTH];
        calc_active = (state != IDLE);
        write_back  = (state == STEP_CALC) && !calc_ovf && (num_sweep_shifts != '0) && !overflow;
        tick_idle   = (state == IDLE) && clk_sweep && (timer != '0);
        reload      = (sweep_pace == '0) ? TIMER_WIDTH'(8) : TIMER_WIDTH'(sweep_pace);
        lockout     = neg_used && !sweep_decreasing;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow          <= 1'b0;
            shadow_frequency  <= '0;
            freq_update_valid <= 1'b0;
            freq_update       <= '0;
            timer             <= '0;
            enabled           <= 1'b0;
            neg_used          <= 1'b0;
        end else if (trigger) begin
            overflow          <= 1'b0;
            shadow_frequency  <= frequency;
            freq_update_valid <= 1'b0;
            timer             <= reload;
            enabled           <= (sweep_pace != '0) || (num_sweep_shifts != '0);
            neg_used          <= 1'b0;
        end else begin
            freq_update_valid <= write_back;
            if (write_back) begin
                shadow_frequency <= calc[FREQ_WIDTH-1:0];
                freq_update      <= calc[FREQ_WIDTH-1:0];
            end
            if ((calc_active && calc_ovf) || lockout)
                overflow <= 1'b1;
            if (calc_active && sweep_decreasing)
                neg_used <= 1'b1;
            if (tick_idle)
                timer <= (timer == TIMER_WIDTH'(1)) ? reload : timer - TIMER_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_gb_sweep_unit.sv
// Bench for gb_sweep_unit: directed scenarios plus random traffic, compared
// cycle by cycle against a queue-based behavioural model of the sweep.
module tb_gb_sweep_unit;

    localparam int FW   = 11;
    localparam int FMAX = (1 << FW) - 1;
    localparam int OP_CHECK = 1;
    localparam int OP_STEP  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clk_sweep = 1'b0;
    logic          trigger = 1'b0;
    logic [2:0]    pace = '0;
    logic          decr = 1'b0;
    logic [2:0]    nsh = '0;
    logic [FW-1:0] freq = '0;

    logic          overflow;
    logic [FW-1:0] shadow_frequency;
    logic          freq_update_valid;
    logic [FW-1:0] freq_update;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;

    int m_shadow, m_timer, m_upd;
    bit m_ovf, m_neg, m_en, m_valid;
    int ops[$];

    gb_sweep_unit #(.FREQ_WIDTH(FW), .PACE_WIDTH(3), .SHIFT_WIDTH(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .clk_sweep        (clk_sweep),
        .trigger          (trigger),
        .sweep_pace       (pace),
        .sweep_decreasing (decr),
        .num_sweep_shifts (nsh),
        .frequency        (freq),
        .overflow         (overflow),
        .shadow_frequency (shadow_frequency),
        .freq_update_valid(freq_update_valid),
        .freq_update      (freq_update)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sweep behaviour: a trigger schedules a check; an expiring timer
    // schedules a step followed by a check; one scheduled op runs per cycle.
    task automatic model_step();
        int  val;
        int  op;
        bit  ovf_old;
        bit  lock;
        bit  set_ovf;
        if (reset) begin
            m_shadow = 0; m_timer = 0; m_upd = 0;
            m_ovf = 0; m_neg = 0; m_en = 0; m_valid = 0;
            ops.delete();
        end else if (trigger) begin
            m_shadow = int'(freq);
            m_ovf = 0; m_neg = 0; m_valid = 0;
            m_timer = (pace == 0) ? 8 : int'(pace);
            m_en = (pace != 0) || (nsh != 0);
            ops.delete();
            if (nsh != 0) ops.push_back(OP_CHECK);
        end else begin
            ovf_old = m_ovf;
            lock    = m_neg && !decr;
            set_ovf = 0;
            m_valid = 0;
            if (ops.size() > 0) begin
                op  = ops.pop_front();
                val = decr ? m_shadow - (m_shadow >> nsh) : m_shadow + (m_shadow >> nsh);
                if (val > FMAX) set_ovf = 1;
                if (decr) m_neg = 1;
                if (op == OP_STEP && val <= FMAX && nsh != 0 && !ovf_old) begin
                    m_shadow = val;
                    m_upd    = val;
                    m_valid  = 1;
                end
            end else if (clk_sweep && m_timer != 0) begin
                if (m_timer == 1) begin
                    m_timer = (pace == 0) ? 8 : int'(pace);
                    if (m_en && pace != 0) begin
                        ops.push_back(OP_STEP);
                        ops.push_back(OP_CHECK);
                    end
                end else begin
                    m_timer--;
                end
            end
            m_ovf = ovf_old | set_ovf | lock;
        end
    endtask

    task automatic cyc(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            model_step();
            #1;
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("shadow", {21'd0, shadow_frequency}, m_shadow);
            chk("valid", {31'd0, freq_update_valid}, {31'd0, m_valid});
            chk("freq_update", {21'd0, freq_update}, m_upd);
            if (freq_update_valid) pulses++;
        end
    endtask

    task automatic fire(input logic [2:0] p, input logic d, input logic [2:0] s, input logic [FW-1:0] f);
        pace = p; decr = d; nsh = s; freq = f;
        trigger = 1'b1;
        cyc(1);
        trigger = 1'b0;
    endtask

    task automatic tick_once();
        clk_sweep = 1'b1;
        cyc(1);
        clk_sweep = 1'b0;
    endtask

    initial begin
        // reset held two cycles, then idle ticks must produce nothing
        reset = 1'b1;
        cyc(2);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_shadow", {21'd0, shadow_frequency}, 0);
        chk("rst_valid", {31'd0, freq_update_valid}, 0);
        chk("rst_update", {21'd0, freq_update}, 0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            clk_sweep = i[0];
            cyc(1);
        end
        clk_sweep = 1'b0;
        chk("idle_pulses", pulses, 0);

        // decreasing sweep: 0x040 -> 0x030 -> 0x024
        fire(3'd1, 1'b1, 3'd2, 11'h040);
        cyc(2);
        pulses = 0;
        tick_once();
        cyc(3);
        chk("dec_pulses1", pulses, 1);
        chk("dec_shadow1", {21'd0, shadow_frequency}, 32'h030);
        chk("dec_update1", {21'd0, freq_update}, 32'h030);
        tick_once();
        cyc(3);
        chk("dec_pulses2", pulses, 2);
        chk("dec_shadow2", {21'd0, shadow_frequency}, 32'h024);
        chk("dec_overflow", {31'd0, overflow}, 0);

        // trigger-time overflow on add
        fire(3'd1, 1'b0, 3'd1, 11'h700);
        chk("trig_ovf_early", {31'd0, overflow}, 0);
        cyc(1);
        chk("trig_ovf", {31'd0, overflow}, 1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin tick_once(); cyc(2); end
        chk("trig_ovf_pulses", pulses, 0);

        // pace 0: check only, never a write-back
        fire(3'd0, 1'b0, 3'd1, 11'h100);
        pulses = 0;
        clk_sweep = 1'b1;
        cyc(100);
        clk_sweep = 1'b0;
        chk("pace0_pulses", pulses, 0);
        chk("pace0_shadow", {21'd0, shadow_frequency}, 32'h100);
        chk("pace0_overflow", {31'd0, overflow}, 0);

        // negate lockout after a subtract step
        fire(3'd1, 1'b1, 3'd1, 11'h200);
        cyc(2);
        pulses = 0;
        tick_once();
        cyc(3);
        chk("neg_pulse", pulses, 1);
        chk("neg_shadow", {21'd0, shadow_frequency}, 32'h100);
        decr = 1'b0;
        cyc(1);
        chk("neg_lockout", {31'd0, overflow}, 1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin tick_once(); cyc(2); end
        chk("neg_pulses_after", pulses, 0);

        // trigger and tick together: tick ignored, next tick steps
        pace = 3'd1; decr = 1'b1; nsh = 3'd1; freq = 11'h200;
        trigger = 1'b1; clk_sweep = 1'b1;
        pulses = 0;
        cyc(1);
        trigger = 1'b0; clk_sweep = 1'b0;
        cyc(3);
        chk("same_cycle_pulses", pulses, 0);
        tick_once();
        cyc(3);
        chk("same_cycle_step", pulses, 1);
        chk("same_cycle_shadow", {21'd0, shadow_frequency}, 32'h100);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            trigger   = ($urandom_range(0, 39) == 0);
            clk_sweep = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) decr = ~decr;
            if ($urandom_range(0, 29) == 0) begin
                pace = 3'($urandom_range(0, 7));
                nsh  = 3'($urandom_range(0, 7));
                freq = 11'($urandom_range(0, FMAX));
            end
            cyc(1);
        end
        reset = 1'b0; trigger = 1'b0; clk_sweep = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
